// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl
//   Run sequencer that sits in front of the processor top level. It holds the
//   processor in reset for a programmable number of cycles, issues a
//   single-cycle req pulse, counts RUN cycles until the processor reports done
//   or the watchdog expires, and then parks in DONE so the result can be read.
//
// Ports
//   clk          in   1      system clock, all logic on posedge
//   reset        in   1      synchronous, active-high block reset
//   start        in   1      launch request, honoured in IDLE and DONE only
//   proc_done    in   1      processor done, honoured in RUN only
//   proc_reset   out  1      processor reset (high in IDLE and RST)
//   proc_req     out  1      processor req, one-cycle pulse in REQ
//   busy         out  1      high in RST, REQ, RUN
//   finished     out  1      high in DONE
//   timed_out    out  1      last run ended by the watchdog (valid when finished)
//   cycle_count  out  CNT_W  RUN cycles of the current/last run, saturating
//
// States
//   state | meaning
//   IDLE  | after reset, processor held in reset, waiting for start
//   RST   | processor reset asserted for RST_CYCLES cycles
//   REQ   | processor released, req pulsed for one cycle
//   RUN   | counting cycles, waiting for proc_done or watchdog
//   DONE  | run finished, count and timeout flag held, waiting for start

module proc_run_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             proc_done,
    output logic             proc_reset,
    output logic             proc_req,
    output logic             busy,
    output logic             finished,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RST  = 3'd1,
        REQ  = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_t;

    // rst_cnt only ever holds RST_CYCLES-1 down to 0.
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The watchdog compare is done in a domain at least 32 bits wide so a
    // TIMEOUT larger than the counter range simply never matches.
    localparam int CW = (CNT_W > 32) ? CNT_W : 32;
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT) - CW'(1);

    state_t            state, state_nxt;
    logic [RW-1:0]     rst_cnt, rst_cnt_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              to_nxt;
    logic              wd_hit;

    assign wd_hit = WD_EN && (CW'(cycle_count) == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            timed_out   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rst_cnt     <= rst_cnt_nxt;
            cycle_count <= cnt_nxt;
            timed_out   <= to_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        cnt_nxt     = cycle_count;
        to_nxt      = timed_out;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt   = RST;
                    rst_cnt_nxt = RST_LOAD;
                    cnt_nxt     = '0;
                    to_nxt      = 1'b0;
                end
            end
            RST: begin
                if (rst_cnt == '0) begin
                    state_nxt = REQ;
                end else begin
                    rst_cnt_nxt = rst_cnt - RW'(1);
                end
            end
            REQ: begin
                state_nxt = RUN;
            end
            RUN: begin
                // The exit edge counts as a RUN cycle too.
                if (cycle_count != CNT_MAX) begin
                    cnt_nxt = cycle_count + CNT_W'(1);
                end
                // Done has priority over a watchdog hit in the same cycle.
                if (proc_done) begin
                    state_nxt = DONE;
                    to_nxt    = 1'b0;
                end else if (wd_hit) begin
                    state_nxt = DONE;
                    to_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs; the processor stays out of reset in DONE so its state
    // remains inspectable.
    always_comb begin
        proc_reset = 1'b0;
        proc_req   = 1'b0;
        busy       = 1'b0;
        finished   = 1'b0;
        case (state)
            IDLE: proc_reset = 1'b1;
            RST: begin
                proc_reset = 1'b1;
                busy       = 1'b1;
            end
            REQ: begin
                proc_req = 1'b1;
                busy     = 1'b1;
            end
            RUN:  busy = 1'b1;
            DONE: finished = 1'b1;
            default: proc_reset = 1'b1;
        endcase
    end

endmodule
